// File: rtl/axis_line_fifo.sv
// axis_line_fifo: AXI-Stream pixel FIFO with first-word fall-through output,
// fill level reporting, optional whole-line release (packet mode) and an
// input-side line-structure checker that flags short/long lines and
// start-of-frame markers that arrive mid-line.
module axis_line_fifo #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_FIFO_DEPTH  = 16,
  parameter int PACKET_MODE        = 0,
  parameter int IMG_WIDTH          = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  input  logic                              s00_axis_tuser,
  input  logic                              s00_axis_tvalid,
  output logic                              m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  output logic                              m00_axis_tuser,
  input  logic                              m00_axis_tready,
  output logic [$clog2(C_AXIS_FIFO_DEPTH):0] fill_level,
  output logic                              line_len_err,
  output logic                              sof_err
);

  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int AW = $clog2(C_AXIS_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = C_AXIS_TDATA_WIDTH + SW + 2;
  localparam int CW = $clog2(IMG_WIDTH) + 1;
  localparam logic [LW-1:0] DEPTH_C = LW'(C_AXIS_FIFO_DEPTH);
  localparam logic [CW:0]   IMG_W_C = (CW + 1)'(IMG_WIDTH);

  // Entry layout: {tuser, tlast, tstrb, tdata}
  logic [EW-1:0] mem_q [C_AXIS_FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [LW-1:0] lines_q, lines_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          len_err_q, len_err_d;
  logic          sof_err_q, sof_err_d;
  logic          wr_en, rd_en, full, out_vld;

  assign full = (fill_q == DEPTH_C);
  assign {m00_axis_tuser, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = mem_q[rd_ptr_q];

  // Ready depends only on registered fill and reset, never on m00_axis_tready.
  assign s00_axis_tready = !reset && !full;
  assign m00_axis_tvalid = out_vld && !reset;
  assign wr_en           = s00_axis_tvalid && s00_axis_tready;
  assign rd_en           = m00_axis_tvalid && m00_axis_tready;

  // Status outputs read as zero for the whole time reset is held.
  assign fill_level   = reset ? '0 : fill_q;
  assign line_len_err = len_err_q && !reset;
  assign sof_err      = sof_err_q && !reset;

  // Output qualification: cut-through, or hold until a full line (or a full FIFO) is stored.
  always_comb begin
    out_vld = (fill_q != '0);
    if (PACKET_MODE != 0) begin
      out_vld = out_vld && ((lines_q != '0) || full);
    end
  end

  // Next-state for pointers, occupancy, stored-line count and the line checker.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    lines_d   = lines_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    sof_err_d = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + LW'(1);
      2'b01:   fill_d = fill_q - LW'(1);
      default: fill_d = fill_q;
    endcase

    case ({wr_en && s00_axis_tlast, rd_en && m00_axis_tlast})
      2'b10:   lines_d = lines_q + LW'(1);
      2'b01:   lines_d = lines_q - LW'(1);
      default: lines_d = lines_q;
    endcase

    // Checker looks at accepted beats only; the count before this beat is what matters.
    if (wr_en) begin
      sof_err_d = s00_axis_tuser && (cnt_q != '0);
      if (s00_axis_tlast) begin
        len_err_d = (({1'b0, cnt_q} + (CW + 1)'(1)) != IMG_W_C);
        cnt_d     = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      lines_q   <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      lines_q   <= lines_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
      sof_err_q <= sof_err_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s00_axis_tuser, s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_line_fifo.sv
// Testbench for axis_line_fifo: one cut-through and one packet-mode instance,
// randomized beats checked against a queue-based reference model.
module tb_axis_line_fifo;

  localparam int W     = 32;
  localparam int SW    = W / 8;
  localparam int DEPTH = 16;
  localparam int IMG   = 8;
  localparam int LW    = 5;
  localparam int EW    = W + SW + 2;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          c_s_tready, c_s_tlast, c_s_tuser, c_s_tvalid;
  logic          c_m_tvalid, c_m_tlast, c_m_tuser, c_m_tready, c_len_err, c_sof_err;
  logic [W-1:0]  c_s_tdata, c_m_tdata;
  logic [SW-1:0] c_s_tstrb, c_m_tstrb;
  logic [LW-1:0] c_fill;

  logic          p_s_tready, p_s_tlast, p_s_tuser, p_s_tvalid;
  logic          p_m_tvalid, p_m_tlast, p_m_tuser, p_m_tready, p_len_err, p_sof_err;
  logic [W-1:0]  p_s_tdata, p_m_tdata;
  logic [SW-1:0] p_s_tstrb, p_m_tstrb;
  logic [LW-1:0] p_fill;

  axis_line_fifo #(.C_AXIS_TDATA_WIDTH(W), .C_AXIS_FIFO_DEPTH(DEPTH), .PACKET_MODE(0), .IMG_WIDTH(IMG)) dut_c (
    .clk(clk), .reset(reset),
    .s00_axis_tready(c_s_tready), .s00_axis_tdata(c_s_tdata), .s00_axis_tstrb(c_s_tstrb),
    .s00_axis_tlast(c_s_tlast), .s00_axis_tuser(c_s_tuser), .s00_axis_tvalid(c_s_tvalid),
    .m00_axis_tvalid(c_m_tvalid), .m00_axis_tdata(c_m_tdata), .m00_axis_tstrb(c_m_tstrb),
    .m00_axis_tlast(c_m_tlast), .m00_axis_tuser(c_m_tuser), .m00_axis_tready(c_m_tready),
    .fill_level(c_fill), .line_len_err(c_len_err), .sof_err(c_sof_err)
  );

  axis_line_fifo #(.C_AXIS_TDATA_WIDTH(W), .C_AXIS_FIFO_DEPTH(DEPTH), .PACKET_MODE(1), .IMG_WIDTH(IMG)) dut_p (
    .clk(clk), .reset(reset),
    .s00_axis_tready(p_s_tready), .s00_axis_tdata(p_s_tdata), .s00_axis_tstrb(p_s_tstrb),
    .s00_axis_tlast(p_s_tlast), .s00_axis_tuser(p_s_tuser), .s00_axis_tvalid(p_s_tvalid),
    .m00_axis_tvalid(p_m_tvalid), .m00_axis_tdata(p_m_tdata), .m00_axis_tstrb(p_m_tstrb),
    .m00_axis_tlast(p_m_tlast), .m00_axis_tuser(p_m_tuser), .m00_axis_tready(p_m_tready),
    .fill_level(p_fill), .line_len_err(p_len_err), .sof_err(p_sof_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit sel_pkt = 1'b0;

  // Reference model: stored beats in order, accepted beats in the current line, pending pulses.
  logic [EW-1:0] mq[$];
  int mcnt;
  bit pend_len, pend_sof;

  logic          o_tready, o_tvalid, o_len, o_sof;
  logic [LW-1:0] o_fill;
  logic [EW-1:0] o_head;
  logic          e_tready, e_tvalid, e_len, e_sof;
  logic [LW-1:0] e_fill;
  logic [EW-1:0] e_head;
  bit            e_rd;

  task automatic model_clear();
    mq.delete();
    mcnt = 0;
    pend_len = 1'b0;
    pend_sof = 1'b0;
  endtask

  task automatic idle_inputs();
    c_s_tvalid = 1'b0; p_s_tvalid = 1'b0;
    c_m_tready = 1'b0; p_m_tready = 1'b0;
    c_s_tdata = '0; p_s_tdata = '0; c_s_tstrb = '0; p_s_tstrb = '0;
    c_s_tlast = 1'b0; p_s_tlast = 1'b0; c_s_tuser = 1'b0; p_s_tuser = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus to the selected instance; records observed and predicted outputs.
  task automatic drive_cycle(input bit vld, input logic [W-1:0] d, input bit last, input bit user, input bit rdy);
    logic [SW-1:0] s;
    int nl;
    bit wr;
    s = SW'($urandom);
    @(negedge clk);
    c_s_tdata = d; p_s_tdata = d; c_s_tstrb = s; p_s_tstrb = s;
    c_s_tlast = last; p_s_tlast = last; c_s_tuser = user; p_s_tuser = user;
    c_s_tvalid = vld & ~sel_pkt; p_s_tvalid = vld & sel_pkt;
    c_m_tready = rdy & ~sel_pkt; p_m_tready = rdy & sel_pkt;
    #1;
    if (sel_pkt) begin
      o_tready = p_s_tready; o_tvalid = p_m_tvalid; o_fill = p_fill;
      o_len = p_len_err; o_sof = p_sof_err; o_head = {p_m_tuser, p_m_tlast, p_m_tstrb, p_m_tdata};
    end else begin
      o_tready = c_s_tready; o_tvalid = c_m_tvalid; o_fill = c_fill;
      o_len = c_len_err; o_sof = c_sof_err; o_head = {c_m_tuser, c_m_tlast, c_m_tstrb, c_m_tdata};
    end
    nl = 0;
    foreach (mq[i]) if (mq[i][EW-2]) nl++;
    e_tready = (mq.size() != DEPTH);
    e_tvalid = (mq.size() != 0) && (!sel_pkt || nl != 0 || mq.size() == DEPTH);
    e_fill   = LW'(mq.size());
    e_head   = (mq.size() != 0) ? mq[0] : '0;
    e_len    = pend_len;
    e_sof    = pend_sof;
    wr       = vld && e_tready;
    e_rd     = e_tvalid && rdy;
    pend_len = 1'b0;
    pend_sof = 1'b0;
    if (e_rd) void'(mq.pop_front());
    if (wr) begin
      mq.push_back({user, last, s, d});
      if (user && mcnt != 0) pend_sof = 1'b1;
      if (last) begin
        pend_len = (mcnt + 1 != IMG);
        mcnt = 0;
      end else if (mcnt < CMAX) begin
        mcnt++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    n_cmp++;
    if ({c_s_tready, c_m_tvalid, c_fill, c_len_err, c_sof_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_cut: got rdy/vld/fill/len/sof %b/%b/%0d/%b/%b want all 0", c_s_tready, c_m_tvalid, c_fill, c_len_err, c_sof_err);
    end
    n_cmp++;
    if ({p_s_tready, p_m_tvalid, p_fill, p_len_err, p_sof_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_pkt: got rdy/vld/fill/len/sof %b/%b/%0d/%b/%b want all 0", p_s_tready, p_m_tvalid, p_fill, p_len_err, p_sof_err);
    end
    reset_dut();
  endtask

  task automatic test_cut_through();
    int reads;
    sel_pkt = 1'b0;
    reset_dut();
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive_cycle(1'b1, W'(i), i == 7, i == 0, 1'b1);
      else       drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (o_tvalid === 1'b1) reads++;
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL cut_ctl cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL cut_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
    n_cmp++;
    if (reads != 8) begin n_bad++; $display("FAIL cut_reads: got %0d want 8", reads); end
  endtask

  task automatic test_backpressure();
    int reads;
    sel_pkt = 1'b0;
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL bp_fill cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
    end
    n_cmp++;
    if ({o_tready, o_fill} !== {1'b0, LW'(16)}) begin
      n_bad++;
      $display("FAIL bp_full: got rdy=%b fill=%0d want rdy=0 fill=16", o_tready, o_fill);
    end
    reads = 0;
    for (int i = 0; i < 19; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (o_tvalid === 1'b1) reads++;
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL bp_drain cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL bp_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
    n_cmp++;
    if (reads != 16) begin n_bad++; $display("FAIL bp_reads: got %0d want 16", reads); end
  endtask

  task automatic test_packet_mode();
    int reads;
    sel_pkt = 1'b1;
    reset_dut();
    reads = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 8) drive_cycle(1'b1, W'($urandom), i == 7, i == 0, 1'b1);
      else       drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (o_tvalid === 1'b1) reads++;
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL pkt_ctl cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL pkt_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
    n_cmp++;
    if (reads != 8) begin n_bad++; $display("FAIL pkt_reads: got %0d want 8", reads); end
    // Line longer than the FIFO: released once full, then random drain and a late tlast.
    for (int i = 0; i < 60; i++) begin
      if (i < 20)      drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      else if (i < 34) drive_cycle(1'b1, W'($urandom), i == 33, 1'b0, 1'($urandom_range(0, 1)));
      else             drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL pkt_long cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL pkt_long_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
  endtask

  task automatic test_checker();
    int n_len, n_sof;
    sel_pkt = 1'b0;
    reset_dut();
    n_len = 0;
    n_sof = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 7)       drive_cycle(1'b1, W'($urandom), i == 6, i == 0, 1'b1);
      else if (i < 15) drive_cycle(1'b1, W'($urandom), i == 14, i == 10, 1'b1);
      else             drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (o_len === 1'b1) n_len++;
      if (o_sof === 1'b1) n_sof++;
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL chk_ctl cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL chk_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
    n_cmp++;
    if (n_len != 1) begin n_bad++; $display("FAIL chk_len_pulses: got %0d want 1", n_len); end
    n_cmp++;
    if (n_sof != 1) begin n_bad++; $display("FAIL chk_sof_pulses: got %0d want 1", n_sof); end
  endtask

  task automatic test_simultaneous();
    sel_pkt = 1'b0;
    reset_dut();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_fill !== LW'(5)) begin n_bad++; $display("FAIL simul_level: got %0d want 5", o_fill); end
    for (int i = 0; i < 80; i++) begin
      if (i < 40) drive_cycle(1'($urandom_range(0, 3) != 0), W'($urandom), $urandom_range(0, 7) == 0, 1'b0, 1'($urandom_range(0, 1)));
      else        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL simul_ctl cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL simul_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
  endtask

  task automatic test_reset_midline();
    int n_len;
    sel_pkt = 1'b0;
    reset_dut();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'(i), 1'b0, i == 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    n_cmp++;
    if ({c_s_tready, c_m_tvalid, c_fill} !== '0) begin
      n_bad++;
      $display("FAIL midreset_hold: got rdy/vld/fill %b/%b/%0d want 0/0/0", c_s_tready, c_m_tvalid, c_fill);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_len = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive_cycle(1'b1, W'($urandom), i == 7, i == 0, 1'b1);
      else       drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (o_len === 1'b1) n_len++;
      n_cmp++;
      if ({o_tready, o_tvalid, o_fill, o_len, o_sof} !== {e_tready, e_tvalid, e_fill, e_len, e_sof}) begin
        n_bad++;
        $display("FAIL midreset_ctl cyc %0d: got %b want %b (rdy,vld,fill,len,sof)", i, {o_tready, o_tvalid, o_fill, o_len, o_sof}, {e_tready, e_tvalid, e_fill, e_len, e_sof});
      end
      if (e_tvalid) begin
        n_cmp++;
        if (o_head !== e_head) begin n_bad++; $display("FAIL midreset_data cyc %0d: got %h want %h", i, o_head, e_head); end
      end
    end
    n_cmp++;
    if (n_len != 0) begin n_bad++; $display("FAIL midreset_len_pulses: got %0d want 0", n_len); end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_cut_through();
    test_backpressure();
    test_packet_mode();
    test_checker();
    test_simultaneous();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1);
  end

endmodule
